// File: rtl/wb_arbiter_rr_if.sv
// Wishbone classic point-to-point bundle. The master modport drives the request
// side; the slave modport returns read data, ack and the abort error pulse.
interface wb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack;
  logic                  err;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_rr.sv
// Two-master Wishbone classic arbiter: round-robin grant, bus hold until cyc drops,
// and a stall timeout that aborts a hung transfer with a one-cycle error pulse.
module wb_arbiter_rr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.master       s,
  output logic [1:0] gnt
);
  localparam bit              TO_EN    = (TIMEOUT > 0);
  localparam int              CNT_W    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2,
    ABT0 = 3'd3,
    ABT1 = 3'd4
  } state_t;

  state_t           state_r;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       gnt_r;
  logic             sel_cyc_s;
  logic             sel_stb_s;
  logic             timeout_s;

  // Request and strobe of whichever master currently owns the bus.
  always_comb begin
    sel_cyc_s = 1'b0;
    sel_stb_s = 1'b0;
    case (state_r)
      GNT0: begin
        sel_cyc_s = m0.cyc;
        sel_stb_s = m0.stb;
      end
      GNT1: begin
        sel_cyc_s = m1.cyc;
        sel_stb_s = m1.stb;
      end
      default: begin
        sel_cyc_s = 1'b0;
        sel_stb_s = 1'b0;
      end
    endcase
  end

  // An ack in the last allowed cycle wins over the timeout.
  assign timeout_s = TO_EN && sel_cyc_s && sel_stb_s && !s.ack && (cnt_r == CNT_LAST);

  // Route the owning master onto the slave side; reset forces the bus idle at once.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = {ADDR_WIDTH{1'b0}};
    s.dat_w = {DATA_WIDTH{1'b0}};
    if (!rst) begin
      case (state_r)
        GNT0: begin
          s.cyc   = m0.cyc;
          s.stb   = m0.stb;
          s.we    = m0.we;
          s.adr   = m0.adr;
          s.dat_w = m0.dat_w;
        end
        GNT1: begin
          s.cyc   = m1.cyc;
          s.stb   = m1.stb;
          s.we    = m1.we;
          s.adr   = m1.adr;
          s.dat_w = m1.dat_w;
        end
        default: begin
          s.cyc = 1'b0;
          s.stb = 1'b0;
        end
      endcase
    end else begin
      s.cyc = 1'b0;
      s.stb = 1'b0;
    end
  end

  // Return path: ack and error only reach the owner, and never during reset.
  always_comb begin
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    if (!rst) begin
      case (state_r)
        GNT0: begin
          m0.ack = s.ack;
          m0.err = timeout_s;
        end
        GNT1: begin
          m1.ack = s.ack;
          m1.err = timeout_s;
        end
        default: begin
          m0.ack = 1'b0;
          m1.ack = 1'b0;
        end
      endcase
    end else begin
      m0.ack = 1'b0;
      m1.ack = 1'b0;
    end
  end

  // Grant FSM with round-robin pointer, stall counter and registered grant vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= {CNT_W{1'b0}};
      gnt_r   <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (m0.cyc && (!m1.cyc || last_r)) begin
            state_r <= GNT0;
            last_r  <= 1'b0;
            gnt_r   <= 2'b01;
          end else if (m1.cyc) begin
            state_r <= GNT1;
            last_r  <= 1'b1;
            gnt_r   <= 2'b10;
          end else begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
          end
        end
        GNT0, GNT1: begin
          if (!sel_cyc_s) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (timeout_s) begin
            state_r <= (state_r == GNT0) ? ABT0 : ABT1;
            gnt_r   <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (sel_stb_s && !s.ack) begin
            cnt_r <= cnt_r + 1'b1;
          end else begin
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        ABT0: begin
          cnt_r <= {CNT_W{1'b0}};
          gnt_r <= 2'b00;
          if (!m0.cyc) begin
            state_r <= IDLE;
          end else begin
            state_r <= ABT0;
          end
        end
        ABT1: begin
          cnt_r <= {CNT_W{1'b0}};
          gnt_r <= 2'b00;
          if (!m1.cyc) begin
            state_r <= IDLE;
          end else begin
            state_r <= ABT1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          gnt_r   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt = gnt_r;
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Randomized scoreboard bench for wb_arbiter_rr: a grant-order/transfer model feeds
// queues that an independent negedge monitor drains and compares.
module tb_wb_arbiter_rr;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  wb_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus),
    .gnt (gnt)
  );

  // Test slave: returns ~adr, acks after slave_waits stalled cycles.
  int   slave_waits = 0;
  int   wcnt = 0;
  logic ack_force = 1'b0;
  assign s_bus.dat_r = ~s_bus.adr;
  assign s_bus.err   = 1'b0;
  assign s_bus.ack   = ack_force | (s_bus.cyc & s_bus.stb & (wcnt == slave_waits));
  always @(posedge clk) begin
    if (s_bus.cyc && s_bus.stb && !s_bus.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    bit         err;
    bit         we;
    logic [7:0] adr;
    logic [7:0] wdat;
  } exp_t;
  typedef struct {
    bit         we;
    logic [7:0] adr;
    logic [7:0] dat;
    int         waits;
  } xfer_t;

  exp_t  q0[$];
  exp_t  q1[$];
  int    gq[$];
  xfer_t dir_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    model_last = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within bound", name);
  endtask

  task automatic set_cyc(input int m, input logic v);
    if (m == 0) m0_bus.cyc = v;
    else m1_bus.cyc = v;
  endtask

  task automatic set_req(input int m, input logic stb, input logic we, input logic [7:0] adr,
                         input logic [7:0] dat);
    if (m == 0) begin
      m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr; m0_bus.dat_w = dat;
    end else begin
      m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr; m1_bus.dat_w = dat;
    end
  endtask

  function automatic logic resp_of(input int m);
    return (m == 0) ? (m0_bus.ack | m0_bus.err) : (m1_bus.ack | m1_bus.err);
  endfunction

  task automatic wait_grant(input int exp_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt != 2'b00) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("grant_wait");
    else check("grant_latency", lat, exp_lat);
  endtask

  task automatic xfer(input int m, input xfer_t x, output bit aborted);
    exp_t e;
    bit   seen;
    e.err  = (x.waits >= TO);
    e.we   = x.we;
    e.adr  = x.adr;
    e.wdat = x.dat;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
    aborted = e.err;
    @(posedge clk); #1;
    slave_waits = x.waits;
    set_req(m, 1'b1, x.we, x.adr, x.dat);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_of(m)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("xfer_response");
  endtask

  task automatic tenure(input int m);
    int    nx;
    int    sel;
    bit    ab;
    xfer_t x;
    nx = (dir_q.size() != 0) ? dir_q.size() : $urandom_range(1, 3);
    ab = 1'b0;
    for (int k = 0; k < nx; k++) begin
      if (dir_q.size() != 0) begin
        x = dir_q.pop_front();
      end else begin
        sel     = $urandom_range(0, 9);
        x.we    = 1'($urandom_range(0, 1));
        x.adr   = 8'($urandom);
        x.dat   = 8'($urandom);
        x.waits = (sel < 6) ? (sel % 3) : ((sel < 8) ? 3 : 6);
      end
      xfer(m, x, ab);
      if (ab) break;
    end
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 8'h00, 8'h00);
    if (ab) begin
      // Master still holds cyc after the abort: bus must already be released.
      @(negedge clk);
      check("abort_bus_idle", {gnt, s_bus.cyc, s_bus.stb}, 4'b0000);
      @(posedge clk); #1;
    end
    set_cyc(m, 1'b0);
  endtask

  task automatic run_round(input int req);
    int w;
    if (req == 3) w = (model_last == 1) ? 0 : 1;
    else w = (req == 1) ? 0 : 1;
    gq.push_back(w);
    if (req == 3) gq.push_back(1 - w);
    @(posedge clk); #1;
    if (req != 2) set_cyc(0, 1'b1);
    if (req != 1) set_cyc(1, 1'b1);
    wait_grant(1);
    model_last = w;
    tenure(w);
    if (req == 3) begin
      wait_grant(2);
      model_last = 1 - w;
      tenure(1 - w);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic mon_resp(input int m);
    exp_t       e;
    logic [7:0] inv;
    logic [1:0] kind;
    logic [7:0] rd;
    kind = (m == 0) ? {m0_bus.ack, m0_bus.err} : {m1_bus.ack, m1_bus.err};
    rd   = (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_resp: master %0d got ack/err %b, expected none", m, kind);
    end else begin
      e   = (m == 0) ? q0.pop_front() : q1.pop_front();
      inv = ~e.adr;
      check("resp_kind", kind, e.err ? 2'b01 : 2'b10);
      if (!e.err) begin
        check("resp_adr", s_bus.adr, e.adr);
        check("resp_we", s_bus.we, e.we);
        if (e.we) check("resp_wdat", s_bus.dat_w, e.wdat);
        else check("resp_rdat", rd, inv);
      end
    end
  endtask

  // Monitor: grant order, dead cycle, bus routing and responses, sampled at negedge.
  initial begin : monitor
    logic [1:0]  prev;
    logic [36:0] got_v;
    logic [36:0] exp_v;
    int          w;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 2'b00;
      end else begin
        check("gnt_legal", {63'd0, gnt != 2'b11}, 64'd1);
        if (prev != 2'b00 && gnt != 2'b00) check("dead_cycle", gnt, prev);
        if (prev == 2'b00 && gnt != 2'b00) begin
          if (gq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_order: got %b, expected no grant", gnt);
          end else begin
            w = gq.pop_front();
            check("grant_order", gnt, (w == 0) ? 2'b01 : 2'b10);
          end
        end
        got_v = {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w,
                 m0_bus.ack, m1_bus.ack, m0_bus.dat_r, m1_bus.dat_r};
        if (gnt == 2'b01)
          exp_v = {m0_bus.cyc, m0_bus.stb, m0_bus.we, m0_bus.adr, m0_bus.dat_w,
                   s_bus.ack, 1'b0, s_bus.dat_r, s_bus.dat_r};
        else if (gnt == 2'b10)
          exp_v = {m1_bus.cyc, m1_bus.stb, m1_bus.we, m1_bus.adr, m1_bus.dat_w,
                   1'b0, s_bus.ack, s_bus.dat_r, s_bus.dat_r};
        else
          exp_v = {3'b000, 8'h00, 8'h00, 2'b00, s_bus.dat_r, s_bus.dat_r};
        check("bus_route", got_v, exp_v);
        if (m0_bus.ack || m0_bus.err) mon_resp(0);
        if (m1_bus.ack || m1_bus.err) mon_resp(1);
        prev = gnt;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    xfer_t x;
    rst = 1'b1;
    set_cyc(0, 1'b1);
    set_cyc(1, 1'b1);
    set_req(0, 1'b1, 1'b0, 8'h11, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h22, 8'h00);
    slave_waits = 10;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt, 2'b00);
      check("rst_s_cyc", {s_bus.cyc, s_bus.stb}, 2'b00);
    end
    gq.push_back(0);
    gq.push_back(1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_grant(1);
    model_last = 0;
    @(posedge clk); #1;
    set_cyc(0, 1'b0);
    wait_grant(2);
    model_last = 1;
    @(posedge clk); #1;
    set_cyc(1, 1'b0);

    // Single read by m1 from address 05.
    x = '{we: 1'b0, adr: 8'h05, dat: 8'h00, waits: 0};
    dir_q.push_back(x);
    run_round(2);

    // Bus hold: m0 does three writes while m1 waits.
    for (int k = 1; k <= 3; k++) begin
      x = '{we: 1'b1, adr: 8'(k), dat: 8'(8'hA0 + k), waits: 1};
      dir_q.push_back(x);
    end
    run_round(3);

    // Round robin with both masters contending.
    for (int k = 0; k < 4; k++) begin
      x = '{we: 1'b0, adr: 8'(8'h30 + k), dat: 8'h00, waits: 0};
      dir_q.push_back(x);
      run_round(3);
    end

    // Timeout abort, then ack exactly on the timeout cycle.
    x = '{we: 1'b0, adr: 8'h40, dat: 8'h00, waits: 6};
    dir_q.push_back(x);
    run_round(3);
    x = '{we: 1'b1, adr: 8'h41, dat: 8'h5A, waits: 3};
    dir_q.push_back(x);
    run_round(1);

    for (int r = 0; r < 40; r++) run_round($urandom_range(1, 3));

    // Reset in the middle of a stalled transfer with a stray slave ack.
    gq.push_back(0);
    @(posedge clk); #1;
    set_cyc(0, 1'b1);
    wait_grant(1);
    model_last = 0;
    @(posedge clk); #1;
    slave_waits = 10;
    set_req(0, 1'b1, 1'b0, 8'h33, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    check("rst_mid_s_cyc", {s_bus.cyc, s_bus.stb}, 2'b00);
    check("rst_mid_ack", {m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err}, 4'b0000);
    @(posedge clk); #1;
    ack_force = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_cyc(0, 1'b0);
    @(negedge clk);
    check("rst_mid_gnt", {gnt, s_bus.cyc}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1;
    run_round(3);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("leftover_expected", q0.size() + q1.size() + gq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
